// File: rtl/xosera_bus_master.sv
// Xosera host-bus initiator: turns a single-cycle 16-bit register request
// into one or two strobed 8-bit bus cycles (high byte first, then low byte).
module xosera_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [3:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  input  logic [7:0]  bus_data_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  // Phase counter reload values (counter counts down to 0 in each state)
  localparam logic [1:0] SETUP_LD  = 2'(SETUP_CYC - 1);
  localparam logic [1:0] STROBE_LD = 2'(STROBE_CYC - 1);
  localparam logic [1:0] HOLD_LD   = 2'(HOLD_CYC - 1);

  logic [1:0]  state_reg, state_next;
  logic [1:0]  phase_reg, phase_next;
  logic        lo_reg, lo_next;          // byte flag: 0=HI byte, 1=LO byte
  logic        write_reg, byte_reg;
  logic [3:0]  reg_num_reg;
  logic [15:0] wdata_reg;
  logic        accept;
  logic        capture;
  logic        done_next;

  // Effective request fields: live inputs on the accept cycle so the first
  // SETUP cycle already drives the new address/data.
  logic        write_eff;
  logic [3:0]  reg_eff;
  logic [15:0] wdata_eff;

  assign accept    = (state_reg == IDLE) && req;
  assign write_eff = accept ? req_write : write_reg;
  assign reg_eff   = accept ? req_reg   : reg_num_reg;
  assign wdata_eff = accept ? req_wdata : wdata_reg;

  // Next-state logic: phase counter sequences SETUP -> STROBE -> HOLD per byte
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = SETUP;
          phase_next = SETUP_LD;
          lo_next    = req_byte;
        end
      end
      SETUP: begin
        if (phase_reg == 2'd0) begin
          state_next = STROBE;
          phase_next = STROBE_LD;
        end else begin
          phase_next = phase_reg - 2'd1;
        end
      end
      STROBE: begin
        if (phase_reg == 2'd0) begin
          capture    = ~write_reg;
          state_next = HOLD;
          phase_next = HOLD_LD;
        end else begin
          phase_next = phase_reg - 2'd1;
        end
      end
      default: begin // HOLD
        if (phase_reg == 2'd0) begin
          if (!lo_reg) begin
            state_next = SETUP;
            phase_next = SETUP_LD;
            lo_next    = 1'b1;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          phase_next = phase_reg - 2'd1;
        end
      end
    endcase
  end

  // State, request latch and read-data assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      phase_reg   <= 2'd0;
      lo_reg      <= 1'b0;
      write_reg   <= 1'b0;
      byte_reg    <= 1'b0;
      reg_num_reg <= 4'd0;
      wdata_reg   <= 16'd0;
      rdata       <= 16'd0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      lo_reg    <= lo_next;
      if (accept) begin
        write_reg   <= req_write;
        byte_reg    <= req_byte;
        reg_num_reg <= req_reg;
        wdata_reg   <= req_wdata;
      end
      if (capture) begin
        if (lo_reg) begin
          rdata[7:0] <= bus_data_i;
          if (byte_reg) begin
            rdata[15:8] <= 8'd0;
          end
        end else begin
          rdata[15:8] <= bus_data_i;
        end
      end
    end
  end

  // Registered outputs derived from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      bus_cs_n_o    <= 1'b1;
      bus_rd_nwr_o  <= 1'b1;
      bus_reg_num_o <= 4'd0;
      bus_bytesel_o <= 1'b0;
      bus_data_o    <= 8'd0;
    end else begin
      busy       <= (state_next != IDLE);
      done       <= done_next;
      bus_cs_n_o <= (state_next != STROBE);
      if (state_next == IDLE) begin
        bus_rd_nwr_o  <= 1'b1;
        bus_reg_num_o <= 4'd0;
        bus_bytesel_o <= 1'b0;
        bus_data_o    <= 8'd0;
      end else begin
        bus_rd_nwr_o  <= ~write_eff;
        bus_reg_num_o <= reg_eff;
        bus_bytesel_o <= lo_next;
        if (write_eff) begin
          bus_data_o <= lo_next ? wdata_eff[7:0] : wdata_eff[15:8];
        end else begin
          bus_data_o <= 8'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_xosera_bus_master.sv
// Directed bench for xosera_bus_master: default timing instance plus a
// SETUP=2/STROBE=1/HOLD=2 instance sharing the same stimulus.
module tb_xosera_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        req_write;
  logic        req_byte;
  logic [3:0]  req_reg;
  logic [15:0] req_wdata;
  logic [7:0]  bus_data_i;

  logic        busy, done, cs_n, rd_nwr, bytesel;
  logic [15:0] rdata;
  logic [3:0]  reg_num;
  logic [7:0]  data_o;

  logic        busy2, done2, cs_n2, rd_nwr2, bytesel2;
  logic [15:0] rdata2;
  logic [3:0]  reg_num2;
  logic [7:0]  data_o2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xosera_bus_master dut (
    .clk(clk), .reset(reset), .req(req), .req_write(req_write),
    .req_byte(req_byte), .req_reg(req_reg), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata), .bus_cs_n_o(cs_n),
    .bus_rd_nwr_o(rd_nwr), .bus_reg_num_o(reg_num), .bus_bytesel_o(bytesel),
    .bus_data_o(data_o), .bus_data_i(bus_data_i)
  );

  xosera_bus_master #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(2)) dut2 (
    .clk(clk), .reset(reset), .req(req), .req_write(req_write),
    .req_byte(req_byte), .req_reg(req_reg), .req_wdata(req_wdata),
    .busy(busy2), .done(done2), .rdata(rdata2), .bus_cs_n_o(cs_n2),
    .bus_rd_nwr_o(rd_nwr2), .bus_reg_num_o(reg_num2), .bus_bytesel_o(bytesel2),
    .bus_data_o(data_o2), .bus_data_i(bus_data_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One default-timing transfer. Starts at the beginning of the request
  // cycle (#1 after an edge) and returns at the start of cycle ncyc+1.
  task automatic xfer(input logic w, input logic b, input logic [3:0] r,
                      input logic [15:0] wd, input logic [7:0] dhi,
                      input logic [7:0] dlo, input int ncyc, input int pulse_cyc,
                      input logic exp_done0, input logic [15:0] exp_rd);
    int last;
    logic active, lo, strobe, dn;
    logic [16:0] expv, obsv;
    int ph;
    last = b ? 5 : 10;
    req = 1'b1; req_write = w; req_byte = b; req_reg = r; req_wdata = wd;
    if (exp_done0) begin
      @(negedge clk);
      chk("b2b_done_cycle", {30'd0, done, busy}, 32'h2);
    end
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == pulse_cyc) begin
        req = 1'b1; req_write = ~w; req_byte = 1'b1; req_reg = 4'hF; req_wdata = 16'h1111;
      end else begin
        req = 1'b0;
      end
      bus_data_i = (c <= 5) ? dhi : dlo;
      @(negedge clk);
      active = (c <= last);
      lo     = b || (c > 5);
      ph     = (c - 1) % 5;
      strobe = active && (ph >= 1) && (ph <= 3);
      dn     = (c == last + 1);
      expv = {active, dn, ~strobe, active ? ~w : 1'b1, active & lo,
              active ? r : 4'd0,
              (active && w) ? (lo ? wd[7:0] : wd[15:8]) : 8'd0};
      obsv = {busy, done, cs_n, rd_nwr, bytesel, reg_num, data_o};
      chk($sformatf("bus_r%0h_c%0d", r, c), {15'd0, obsv}, {15'd0, expv});
      if (dn) chk($sformatf("rdata_done_r%0h", r), {16'd0, rdata}, {16'd0, exp_rd});
      @(posedge clk); #1;
    end
    req = 1'b0;
    $display("xfer w=%0b byte=%0b reg=%0h wdata=%h rdata=%h", w, b, r, wd, rdata);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_reg = 4'd0; req_wdata = 16'd0; bus_data_i = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_bus", {15'd0, busy, done, cs_n, rd_nwr, bytesel, reg_num, data_o},
        {15'd0, 17'b0_0_1_1_0_0000_00000000});
    chk("reset_rdata", {16'd0, rdata}, 32'd0);
    chk("reset_busy2", {31'd0, busy2}, 32'd0);
    @(posedge clk); #1;
    $display("reset state checked");

    // Word write reg 3, 0xA55A
    xfer(1'b1, 1'b0, 4'd3, 16'hA55A, 8'h00, 8'h00, 12, 0, 1'b0, 16'h0000);
    // Word read reg 9: 0x12 then 0x34
    xfer(1'b0, 1'b0, 4'd9, 16'h0000, 8'h12, 8'h34, 12, 0, 1'b0, 16'h1234);
    chk("rdata_held", {16'd0, rdata}, 32'h1234);
    // Following write leaves rdata
    xfer(1'b1, 1'b0, 4'd5, 16'h0F0F, 8'hEE, 8'hEE, 12, 0, 1'b0, 16'h1234);
    chk("rdata_after_write", {16'd0, rdata}, 32'h1234);
    // Byte write reg 1
    xfer(1'b1, 1'b1, 4'd1, 16'hFF7E, 8'h00, 8'h00, 7, 0, 1'b0, 16'h1234);
    // Byte read reg 2: high byte cleared
    xfer(1'b0, 1'b1, 4'd2, 16'h0000, 8'h99, 8'h55, 7, 0, 1'b0, 16'h0099);
    // Word write with ignored req in cycle 4, then back-to-back read in done cycle
    xfer(1'b1, 1'b0, 4'd7, 16'hC3E1, 8'h00, 8'h00, 10, 4, 1'b0, 16'h0099);
    xfer(1'b0, 1'b0, 4'd8, 16'h0000, 8'hAB, 8'hCD, 12, 0, 1'b1, 16'hABCD);

    // Reset asserted in cycle 3 of a word write
    req = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_reg = 4'd6; req_wdata = 16'h1234;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk); chk("rst_c1_cs", {31'd0, cs_n}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("rst_c2_cs", {31'd0, cs_n}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); chk("rst_c3_cs", {31'd0, cs_n}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_c4_state", {29'd0, busy, done, cs_n}, 32'h1);
    chk("rst_c4_rdata", {16'd0, rdata}, 32'd0);
    for (int c = 5; c <= 12; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("rst_c%0d_idle", c), {29'd0, busy, done, cs_n}, 32'h1);
    end
    @(posedge clk); #1;
    $display("reset mid-transfer checked rdata=%h", rdata);

    // Non-default timing instance, word read
    req = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_reg = 4'hA; req_wdata = 16'h0;
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      bus_data_i = (c <= 5) ? 8'hBE : 8'hEF;
      @(negedge clk);
      chk($sformatf("t2_c%0d", c), {29'd0, busy2, done2, cs_n2},
          {29'd0, (c <= 10), (c == 11), ~((c == 3) || (c == 8))});
      @(posedge clk); #1;
    end
    chk("t2_rdata", {16'd0, rdata2}, 32'hBEEF);
    $display("custom timing read rdata2=%h", rdata2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute run-time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
